// File: rtl/ervp_access_router_multi.sv
// Address-region access router: steers each request to one of NUM_TARGET ports
// and returns replies to the initiator in request order via a tag FIFO.
module ervp_access_router_multi #(
    parameter int BW_ADDR         = 32,
    parameter int BW_ACCESS       = 32,
    parameter int NUM_TARGET      = 3,
    parameter int NUM_TXN_BUFFER  = 4,
    parameter int HAS_DEFAULT     = 1,
    parameter int DEFAULT_TARGET  = NUM_TARGET - 1,
    parameter int WRITE_HAS_REPLY = 0,
    parameter logic [BW_ACCESS-1:0] ERROR_RDATA = BW_ACCESS'(32'hDEAD_BEEF)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             enable,
    output logic                             busy,
    input  logic [NUM_TARGET-1:0]            target_enable,
    input  logic [BW_ADDR*NUM_TARGET-1:0]    region_start_list,
    input  logic [BW_ADDR*NUM_TARGET-1:0]    region_last_list,
    output logic                             access_rcqready,
    input  logic                             access_rcqvalid,
    input  logic [BW_ADDR-1:0]               access_rcqaddr,
    input  logic                             access_rcqwrite,
    input  logic [BW_ACCESS/8-1:0]           access_rcqwstrb,
    input  logic [BW_ACCESS-1:0]             access_rcqwdata,
    output logic                             access_rcyvalid,
    output logic [BW_ACCESS-1:0]             access_rcyrdata,
    output logic                             access_rcyerror,
    input  logic [NUM_TARGET-1:0]            tgt_scqready,
    output logic [NUM_TARGET-1:0]            tgt_scqvalid,
    output logic [BW_ADDR-1:0]               tgt_scqaddr,
    output logic                             tgt_scqwrite,
    output logic [BW_ACCESS/8-1:0]           tgt_scqwstrb,
    output logic [BW_ACCESS-1:0]             tgt_scqwdata,
    input  logic [NUM_TARGET-1:0]            tgt_scyvalid,
    input  logic [BW_ACCESS*NUM_TARGET-1:0]  tgt_scyrdata,
    output logic                             order_violation
);

    localparam int unsigned BW_TAG = $clog2(NUM_TARGET + 1);
    localparam int unsigned BW_PTR = $clog2(NUM_TXN_BUFFER);
    localparam int unsigned BW_CNT = BW_PTR + 1;
    localparam logic [BW_TAG-1:0] ERR_TAG = BW_TAG'(NUM_TARGET);

    logic [BW_TAG-1:0] fifo_tag [NUM_TXN_BUFFER];
    logic [BW_PTR-1:0] wptr;
    logic [BW_PTR-1:0] rptr;
    logic [BW_CNT-1:0] count;
    logic              violation_flag;

    logic [BW_TAG-1:0] sel;
    logic [BW_TAG-1:0] head;
    logic              sel_ready;
    logic              needs_reply;
    logic              fifo_empty;
    logic              fifo_full;
    logic              allowed;
    logic              push;
    logic              pop;
    logic              stray_reply;

    // Region decode: default first, then descending scan so the lowest index wins.
    always_comb begin
        sel = ERR_TAG;
        if (HAS_DEFAULT != 0 && target_enable[DEFAULT_TARGET])
            sel = BW_TAG'(DEFAULT_TARGET);
        for (int i = NUM_TARGET - 1; i >= 0; i--) begin
            if (target_enable[i] &&
                access_rcqaddr >= region_start_list[i*BW_ADDR +: BW_ADDR] &&
                access_rcqaddr <= region_last_list[i*BW_ADDR +: BW_ADDR])
                sel = BW_TAG'(i);
        end
    end

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == BW_CNT'(NUM_TXN_BUFFER));
    assign needs_reply = ~access_rcqwrite | (WRITE_HAS_REPLY != 0);
    assign allowed     = enable & (~needs_reply | ~fifo_full);

    // Request steering; the ERR tag is absorbed here without touching any target.
    always_comb begin
        sel_ready    = 1'b0;
        tgt_scqvalid = '0;
        for (int i = 0; i < NUM_TARGET; i++) begin
            if (sel == BW_TAG'(i)) begin
                sel_ready       = tgt_scqready[i];
                tgt_scqvalid[i] = allowed & access_rcqvalid;
            end
        end
        if (sel == ERR_TAG)
            access_rcqready = allowed;
        else
            access_rcqready = allowed & (~access_rcqvalid | sel_ready);
    end

    assign tgt_scqaddr  = access_rcqaddr;
    assign tgt_scqwrite = access_rcqwrite;
    assign tgt_scqwstrb = access_rcqwstrb;
    assign tgt_scqwdata = access_rcqwdata;

    assign head = fifo_tag[rptr];
    assign push = access_rcqvalid & access_rcqready & needs_reply;

    // Reply selection from the FIFO head; any reply not from the head is stray.
    always_comb begin
        access_rcyvalid = 1'b0;
        access_rcyerror = 1'b0;
        access_rcyrdata = ERROR_RDATA;
        stray_reply     = 1'b0;
        if (!fifo_empty && head == ERR_TAG) begin
            access_rcyvalid = 1'b1;
            access_rcyerror = 1'b1;
        end
        for (int i = 0; i < NUM_TARGET; i++) begin
            if (tgt_scyvalid[i]) begin
                if (!fifo_empty && head == BW_TAG'(i)) begin
                    access_rcyvalid = 1'b1;
                    access_rcyrdata = tgt_scyrdata[i*BW_ACCESS +: BW_ACCESS];
                end else begin
                    stray_reply = 1'b1;
                end
            end
        end
    end

    assign pop = access_rcyvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            violation_flag <= 1'b0;
        end else if (clear) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            violation_flag <= 1'b0;
        end else begin
            if (push) wptr <= wptr + BW_PTR'(1);
            if (pop)  rptr <= rptr + BW_PTR'(1);
            if (push && !pop)
                count <= count + BW_CNT'(1);
            else if (!push && pop)
                count <= count - BW_CNT'(1);
            violation_flag <= violation_flag | stray_reply;
        end
    end

    // Tag storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push && !clear)
            fifo_tag[wptr] <= sel;
    end

    assign busy            = ~fifo_empty;
    assign order_violation = violation_flag;

endmodule

// File: tb/tb_ervp_access_router_multi.sv
// Bench for ervp_access_router_multi: two configurations checked against a
// queue-based reference model every cycle, plus directed literal checks.
module tb_ervp_access_router_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clear_i    [2];
    logic        enable_i   [2];
    logic [2:0]  tgt_en     [2];
    logic [95:0] reg_start  [2];
    logic [95:0] reg_last   [2];
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic        req_write  [2];
    logic [3:0]  req_wstrb  [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  tgt_ready  [2];
    logic [2:0]  rpl_valid  [2];
    logic [95:0] rpl_data   [2];

    logic        busy_o     [2];
    logic        req_ready  [2];
    logic        rcy_valid  [2];
    logic [31:0] rcy_data   [2];
    logic        rcy_error  [2];
    logic [2:0]  scq_valid  [2];
    logic [31:0] scq_addr   [2];
    logic        scq_write  [2];
    logic [3:0]  scq_wstrb  [2];
    logic [31:0] scq_wdata  [2];
    logic        violation  [2];

    int n_chk = 0;
    int n_err = 0;

    ervp_access_router_multi #(.HAS_DEFAULT(1), .WRITE_HAS_REPLY(0)) u0 (
        .clk(clk), .rst(rst), .clear(clear_i[0]), .enable(enable_i[0]), .busy(busy_o[0]),
        .target_enable(tgt_en[0]), .region_start_list(reg_start[0]), .region_last_list(reg_last[0]),
        .access_rcqready(req_ready[0]), .access_rcqvalid(req_valid[0]), .access_rcqaddr(req_addr[0]),
        .access_rcqwrite(req_write[0]), .access_rcqwstrb(req_wstrb[0]), .access_rcqwdata(req_wdata[0]),
        .access_rcyvalid(rcy_valid[0]), .access_rcyrdata(rcy_data[0]), .access_rcyerror(rcy_error[0]),
        .tgt_scqready(tgt_ready[0]), .tgt_scqvalid(scq_valid[0]), .tgt_scqaddr(scq_addr[0]),
        .tgt_scqwrite(scq_write[0]), .tgt_scqwstrb(scq_wstrb[0]), .tgt_scqwdata(scq_wdata[0]),
        .tgt_scyvalid(rpl_valid[0]), .tgt_scyrdata(rpl_data[0]), .order_violation(violation[0]));

    ervp_access_router_multi #(.HAS_DEFAULT(0), .WRITE_HAS_REPLY(1)) u1 (
        .clk(clk), .rst(rst), .clear(clear_i[1]), .enable(enable_i[1]), .busy(busy_o[1]),
        .target_enable(tgt_en[1]), .region_start_list(reg_start[1]), .region_last_list(reg_last[1]),
        .access_rcqready(req_ready[1]), .access_rcqvalid(req_valid[1]), .access_rcqaddr(req_addr[1]),
        .access_rcqwrite(req_write[1]), .access_rcqwstrb(req_wstrb[1]), .access_rcqwdata(req_wdata[1]),
        .access_rcyvalid(rcy_valid[1]), .access_rcyrdata(rcy_data[1]), .access_rcyerror(rcy_error[1]),
        .tgt_scqready(tgt_ready[1]), .tgt_scqvalid(scq_valid[1]), .tgt_scqaddr(scq_addr[1]),
        .tgt_scqwrite(scq_write[1]), .tgt_scqwstrb(scq_wstrb[1]), .tgt_scqwdata(scq_wdata[1]),
        .tgt_scyvalid(rpl_valid[1]), .tgt_scyrdata(rpl_data[1]), .order_violation(violation[1]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic idle(input int k);
        clear_i[k]   = 1'b0;
        enable_i[k]  = 1'b1;
        tgt_en[k]    = 3'b111;
        reg_start[k] = {32'hF000_0000, 32'h0000_1000, 32'h0000_0000};
        reg_last[k]  = {32'hF000_0FFF, 32'h0000_1FFF, 32'h0000_0FFF};
        req_valid[k] = 1'b0;
        req_addr[k]  = 32'h0;
        req_write[k] = 1'b0;
        req_wstrb[k] = 4'hF;
        req_wdata[k] = 32'h1234_5678;
        tgt_ready[k] = 3'b111;
        rpl_valid[k] = 3'b000;
        rpl_data[k]  = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered queue of expected reply sources per instance (3 = internal error).
    int mq [2][$];
    bit model_viol [2];
    bit cfg_default [2] = '{1'b1, 1'b0};
    bit cfg_wreply  [2] = '{1'b0, 1'b1};

    always @(negedge clk) begin
        int sel, head;
        bit needs, allowed, empty, exp_rv, exp_re, stray, exp_rr;
        logic [2:0]  exp_sv;
        logic [31:0] exp_rd;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                model_viol[k] = 1'b0;
            end
            sel = -1;
            for (int i = 0; i < 3; i++)
                if (sel < 0 && tgt_en[k][i] && req_addr[k] >= reg_start[k][i*32 +: 32]
                    && req_addr[k] <= reg_last[k][i*32 +: 32])
                    sel = i;
            if (sel < 0) sel = (cfg_default[k] && tgt_en[k][2]) ? 2 : 3;
            needs   = !req_write[k] || cfg_wreply[k];
            allowed = enable_i[k] && (!needs || mq[k].size() < 4);
            exp_sv  = (sel < 3 && allowed && req_valid[k]) ? 3'(1 << sel) : 3'b000;
            exp_rr  = (sel == 3) ? allowed : (allowed && (!req_valid[k] || tgt_ready[k][sel]));
            empty   = (mq[k].size() == 0);
            head    = empty ? -1 : mq[k][0];
            exp_rv  = 1'b0;
            exp_re  = 1'b0;
            exp_rd  = 32'h0;
            if (head == 3) begin
                exp_rv = 1'b1; exp_re = 1'b1; exp_rd = 32'hDEAD_BEEF;
            end else if (head >= 0 && rpl_valid[k][head]) begin
                exp_rv = 1'b1; exp_rd = rpl_data[k][head*32 +: 32];
            end
            stray = 1'b0;
            for (int j = 0; j < 3; j++)
                if (rpl_valid[k][j] && j != head) stray = 1'b1;

            chk($sformatf("model%0d ready", k), 32'(req_ready[k]), 32'(exp_rr));
            chk($sformatf("model%0d scqvalid", k), 32'(scq_valid[k]), 32'(exp_sv));
            chk($sformatf("model%0d scqaddr", k), scq_addr[k], req_addr[k]);
            chk($sformatf("model%0d rcyvalid", k), 32'(rcy_valid[k]), 32'(exp_rv));
            chk($sformatf("model%0d rcyerror", k), 32'(rcy_error[k]), 32'(exp_re));
            if (exp_rv) chk($sformatf("model%0d rcyrdata", k), rcy_data[k], exp_rd);
            chk($sformatf("model%0d busy", k), 32'(busy_o[k]), 32'(!empty));
            chk($sformatf("model%0d violation", k), 32'(violation[k]), 32'(model_viol[k]));

            if (!rst) begin
                if (clear_i[k]) begin
                    mq[k].delete();
                    model_viol[k] = 1'b0;
                end else begin
                    if (exp_rv) void'(mq[k].pop_front());
                    if (req_valid[k] && exp_rr && needs) mq[k].push_back(sel);
                    if (stray) model_viol[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle(0);
        idle(1);
        @(negedge clk);
        chk("reset busy0", 32'(busy_o[0]), 32'd0);
        chk("reset rcyvalid0", 32'(rcy_valid[0]), 32'd0);
        chk("reset scqvalid0", 32'(scq_valid[0]), 32'd0);
        chk("reset violation1", 32'(violation[1]), 32'd0);
        step();
        rst = 1'b0;

        // In-order return of three reads routed to T0, T1 and default T2
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0010;
        @(negedge clk); chk("route t0", 32'(scq_valid[0]), 32'b001); step();
        req_addr[0] = 32'h0000_1020;
        @(negedge clk); chk("route t1", 32'(scq_valid[0]), 32'b010); step();
        req_addr[0] = 32'h0000_8000;
        @(negedge clk); chk("route default", 32'(scq_valid[0]), 32'b100); step();
        req_valid[0] = 1'b0; rpl_valid[0] = 3'b001;
        @(negedge clk); chk("reply t0 data", rcy_data[0], 32'hA0A0_0000); step();
        rpl_valid[0] = 3'b010;
        @(negedge clk); chk("reply t1 data", rcy_data[0], 32'hB1B1_0001); step();
        rpl_valid[0] = 3'b100;
        @(negedge clk); chk("reply t2 data", rcy_data[0], 32'hC2C2_0002); step();
        rpl_valid[0] = 3'b000;
        @(negedge clk);
        chk("inorder busy", 32'(busy_o[0]), 32'd0);
        chk("inorder violation", 32'(violation[0]), 32'd0);

        // Unmapped read with no default target gives an internal error reply
        req_valid[1] = 1'b1; req_addr[1] = 32'h0000_8000;
        @(negedge clk);
        chk("err scqvalid", 32'(scq_valid[1]), 32'd0);
        chk("err ready", 32'(req_ready[1]), 32'd1);
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("err rcyvalid", 32'(rcy_valid[1]), 32'd1);
        chk("err rdata", rcy_data[1], 32'hDEAD_BEEF);
        chk("err flag", 32'(rcy_error[1]), 32'd1);
        step();
        @(negedge clk); chk("err busy drop", 32'(busy_o[1]), 32'd0);

        // FIFO full: the fifth read waits until the cycle after a pop
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0010;
        repeat (4) step();
        @(negedge clk); chk("full ready", 32'(req_ready[0]), 32'd0); step();
        rpl_valid[0] = 3'b001;
        @(negedge clk); chk("full pop-cycle ready", 32'(req_ready[0]), 32'd0); step();
        rpl_valid[0] = 3'b000;
        @(negedge clk); chk("after pop ready", 32'(req_ready[0]), 32'd1); step();
        req_valid[0] = 1'b0; rpl_valid[0] = 3'b001;
        repeat (4) step();
        rpl_valid[0] = 3'b000;
        @(negedge clk); chk("full drained", 32'(busy_o[0]), 32'd0);

        // Overlapping regions: lowest enabled index wins
        reg_start[0][63:32] = 32'h0; tgt_ready[0] = 3'b000;
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0800;
        @(negedge clk); chk("overlap t0", 32'(scq_valid[0]), 32'b001); step();
        tgt_en[0] = 3'b110;
        @(negedge clk); chk("overlap t1", 32'(scq_valid[0]), 32'b010); step();
        idle(0);

        // Stray reply with empty FIFO, then clear
        rpl_valid[0] = 3'b010;
        @(negedge clk); chk("stray rcyvalid", 32'(rcy_valid[0]), 32'd0); step();
        rpl_valid[0] = 3'b000;
        @(negedge clk); chk("stray sticky", 32'(violation[0]), 32'd1); step();
        clear_i[0] = 1'b1; step();
        clear_i[0] = 1'b0;
        @(negedge clk); chk("clear violation", 32'(violation[0]), 32'd0);

        // Writes: no reply on u0, one reply beat on u1
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h0000_0010;
        @(negedge clk); chk("write route", 32'(scq_valid[0]), 32'b001); step();
        req_valid[0] = 1'b0; req_write[0] = 1'b0;
        @(negedge clk); chk("write noreply busy", 32'(busy_o[0]), 32'd0);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h0000_0010; step();
        req_valid[1] = 1'b0; req_write[1] = 1'b0;
        @(negedge clk); chk("write reply busy", 32'(busy_o[1]), 32'd1); step();
        rpl_valid[1] = 3'b001;
        @(negedge clk); chk("write reply beat", 32'(rcy_valid[1]), 32'd1); step();
        rpl_valid[1] = 3'b000;
        @(negedge clk); chk("write reply done", 32'(busy_o[1]), 32'd0);

        // enable low blocks requests while the outstanding reply drains
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_1020; step();
        enable_i[0] = 1'b0; req_addr[0] = 32'h0000_0010;
        @(negedge clk); chk("disabled ready", 32'(req_ready[0]), 32'd0); step();
        rpl_valid[0] = 3'b010;
        @(negedge clk); chk("disabled drain", 32'(rcy_valid[0]), 32'd1); step();
        idle(0);

        // Simultaneous push and pop, then reset mid-operation
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0010; step();
        req_addr[0] = 32'h0000_1020; rpl_valid[0] = 3'b001; step();
        req_valid[0] = 1'b0; rpl_valid[0] = 3'b000;
        @(negedge clk); chk("push-pop busy", 32'(busy_o[0]), 32'd1); step();
        rst = 1'b1;
        #1 chk("async reset busy", 32'(busy_o[0]), 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
